// File: rtl/eth_pcs_rx_gearbox_sync.sv
// eth_pcs_rx_gearbox_sync: 10GBASE-R receive gearbox turning 32-bit SerDes words into 66b half-blocks, with block lock
// i_clk, i_reset: clock and synchronous active-high reset
// i_rx_data: raw SerDes word, bit 0 earliest
// o_data, o_hdr: half-block payload and sync header (o_hdr[0] first bit)
// o_hdr_valid: first half of a block; o_valid: output strobe and descrambler enable
// o_block_lock: block lock achieved; o_slip: one-cycle bit-slip pulse
module eth_pcs_rx_gearbox_sync #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_rx_data,
  output logic [31:0] o_data,
  output logic [1:0]  o_hdr,
  output logic        o_hdr_valid,
  output logic        o_valid,
  output logic        o_block_lock,
  output logic        o_slip
);
  localparam int CW = $clog2(SH_CNT_MAX + 1);
  typedef enum logic {UNLOCKED, LOCKED} lock_t;
  lock_t st, st_nxt;
  logic [67:0] buf_q, buf_app, buf_sh;
  logic [6:0] fill, fill_app, n;
  logic hdr_ph, slip_pend, take, hdr_chk, hdr_bad, slip_req, win_end;
  logic [CW-1:0] sh_cnt, sh_cnt_inc, sh_cnt_nxt, inv_cnt, inv_cnt_inc, inv_cnt_nxt;
  assign fill_app = fill + 7'd32;
  assign n = (hdr_ph ? 7'd34 : 7'd32) + {6'd0, slip_pend};
  assign take = fill_app >= n;
  assign buf_app = buf_q | ({36'd0, i_rx_data} << fill);
  // a pending slip drops the oldest bit before the header is taken
  assign buf_sh = buf_app >> slip_pend;
  assign hdr_chk = take & hdr_ph;
  assign hdr_bad = buf_sh[0] == buf_sh[1];
  assign sh_cnt_inc = sh_cnt + CW'(1);
  assign inv_cnt_inc = inv_cnt + CW'(hdr_bad);
  assign win_end = sh_cnt_inc == CW'(SH_CNT_MAX);
  assign o_block_lock = st == LOCKED;
  always_comb begin
    slip_req = hdr_chk & (st == UNLOCKED ? hdr_bad : inv_cnt_inc == CW'(SH_INVLD_MAX));
    st_nxt = slip_req ? UNLOCKED : (hdr_chk & win_end) ? LOCKED : st;
    sh_cnt_nxt = !hdr_chk ? sh_cnt : (slip_req | win_end) ? '0 : sh_cnt_inc;
    inv_cnt_nxt = !hdr_chk ? inv_cnt : (slip_req | win_end) ? '0 : inv_cnt_inc;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) st <= UNLOCKED;
    else st <= st_nxt;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_q <= '0;
      fill <= '0;
      hdr_ph <= 1'b1;
      slip_pend <= 1'b0;
      sh_cnt <= '0;
      inv_cnt <= '0;
      o_data <= '0;
      o_hdr <= '0;
      o_hdr_valid <= 1'b0;
      o_valid <= 1'b0;
      o_slip <= 1'b0;
    end else begin
      buf_q <= take ? buf_sh >> (hdr_ph ? 7'd34 : 7'd32) : buf_app;
      fill <= take ? fill_app - n : fill_app;
      hdr_ph <= take ? slip_req | ~hdr_ph : hdr_ph;
      slip_pend <= take ? slip_req : slip_pend;
      sh_cnt <= sh_cnt_nxt;
      inv_cnt <= inv_cnt_nxt;
      o_data <= hdr_ph ? buf_sh[33:2] : buf_sh[31:0];
      o_hdr <= hdr_chk ? buf_sh[1:0] : 2'b00;
      o_hdr_valid <= hdr_chk;
      o_valid <= take;
      o_slip <= slip_req;
    end
  end
endmodule

// File: tb/tb_eth_pcs_rx_gearbox_sync.sv
// tb_eth_pcs_rx_gearbox_sync: table vectors, bit-queue reference model and lock scenarios for the rx gearbox
module tb_eth_pcs_rx_gearbox_sync;
  localparam int CNT_MAX = 64, INV_MAX = 16, NBLK = 4096;
  logic i_clk = 1'b0, i_reset = 1'b1;
  logic [31:0] i_rx_data = '0, o_data;
  logic [1:0] o_hdr;
  logic o_hdr_valid, o_valid, o_block_lock, o_slip;
  int vecs = 0, errs = 0;
  eth_pcs_rx_gearbox_sync #(.SH_CNT_MAX(CNT_MAX), .SH_INVLD_MAX(INV_MAX)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .o_data(o_data), .o_hdr(o_hdr),
    .o_hdr_valid(o_hdr_valid), .o_valid(o_valid), .o_block_lock(o_block_lock), .o_slip(o_slip)
  );
  always #5 i_clk = ~i_clk;
  logic [1:0] src_hdr [NBLK];
  logic [31:0] src_lo [NBLK], src_hi [NBLK];
  bit bad [NBLK];
  logic gq[$], mq[$];
  int gi, ob, hdr_cnt, slip_cnt;
  bit pay_en, m_hdr, m_slip, m_lock;
  int m_cnt, m_inv;
  logic e_valid, e_hv, e_slip, e_lock;
  logic [1:0] e_hdr;
  logic [31:0] e_data;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void gen_block();
    logic [63:0] p;
    logic [1:0] h;
    if (gi >= NBLK) begin
      $display("FAIL gen: block budget exhausted");
      $fatal(1);
    end
    p = {$urandom(), $urandom()};
    h = bad[gi] ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
    src_hdr[gi] = h;
    src_lo[gi] = p[31:0];
    src_hi[gi] = p[63:32];
    gi++;
    gq.push_back(h[0]);
    gq.push_back(h[1]);
    for (int i = 0; i < 64; i++) gq.push_back(p[i]);
  endfunction
  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    while (gq.size() < 32) gen_block();
    for (int i = 0; i < 32; i++) w[i] = gq.pop_front();
    return w;
  endfunction
  function automatic void restart(input int off);
    gq.delete();
    gi = 0;
    ob = 0;
    hdr_cnt = 0;
    slip_cnt = 0;
    while (gq.size() <= off) gen_block();
    for (int i = 0; i < off; i++) void'(gq.pop_front());
  endfunction
  function automatic void clear_bad();
    foreach (bad[i]) bad[i] = 1'b0;
  endfunction
  // reference: a plain bit queue, n oldest bits taken when enough are buffered
  function automatic void model(input logic rst, input logic [31:0] w);
    int nbits;
    bit hbad;
    if (rst) begin
      mq.delete();
      m_hdr = 1; m_slip = 0; m_lock = 0; m_cnt = 0; m_inv = 0;
      e_valid = 0; e_hv = 0; e_slip = 0; e_lock = 0; e_hdr = '0; e_data = '0;
      return;
    end
    for (int i = 0; i < 32; i++) mq.push_back(w[i]);
    nbits = (m_hdr ? 34 : 32) + int'(m_slip);
    e_valid = mq.size() >= nbits;
    e_hv = e_valid && m_hdr;
    e_slip = 0;
    if (e_valid) begin
      if (m_slip) void'(mq.pop_front());
      if (m_hdr) begin
        e_hdr[0] = mq.pop_front();
        e_hdr[1] = mq.pop_front();
      end
      for (int i = 0; i < 32; i++) e_data[i] = mq.pop_front();
      if (m_hdr) begin
        hbad = e_hdr[0] == e_hdr[1];
        m_cnt++;
        m_inv += int'(hbad);
        if ((!m_lock && hbad) || (m_lock && m_inv == INV_MAX)) begin
          e_slip = 1;
          m_lock = 0;
        end else if (m_cnt == CNT_MAX) m_lock = 1;
        if (e_slip || m_cnt == CNT_MAX) begin
          m_cnt = 0;
          m_inv = 0;
        end
      end
      m_slip = e_slip;
      m_hdr = e_slip ? 1'b1 : !m_hdr;
    end
    e_lock = m_lock;
  endfunction
  task automatic step(input logic rst, input logic [31:0] w);
    i_reset = rst;
    i_rx_data = w;
    @(posedge i_clk);
    #1;
    model(rst, w);
    chk("valid", o_valid, e_valid);
    chk("hdr_valid", o_hdr_valid, e_hv);
    chk("slip", o_slip, e_slip);
    chk("lock", o_block_lock, e_lock);
    if (e_valid) chk("data", o_data, e_data);
    if (e_hv) chk("hdr", o_hdr, e_hdr);
    if (o_hdr_valid) hdr_cnt++;
    if (o_slip) slip_cnt++;
    if (pay_en && o_valid) begin
      if (o_hdr_valid) begin
        chk("pay_hdr", o_hdr, src_hdr[ob]);
        chk("pay_lo", o_data, src_lo[ob]);
      end else begin
        chk("pay_hi", o_data, src_hi[ob]);
        ob++;
      end
    end
  endtask
  task automatic run_to_lock(input int max_cyc);
    int cyc = 0;
    while (!o_block_lock && cyc < max_cyc) begin
      step(1'b0, gen_word());
      cyc++;
    end
    chk("lock_reached", o_block_lock, 1);
  endtask
  typedef struct {
    logic [31:0] din;
    logic v, hv, slip;
    logic [1:0] hdr;
    logic [31:0] data;
  } vec_t;
  vec_t tv [7];
  initial begin
    int cyc, nv, nh, drops, k;
    bit found, locked;
    logic [1:0] h;
    logic [31:0] lo, hi;
    tv[0] = '{32'h0000_0002, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_0000};
    tv[1] = '{32'h0000_0003, 1'b1, 1'b1, 1'b0, 2'b10, 32'hC000_0000};
    tv[2] = '{32'h0000_0009, 1'b1, 1'b0, 1'b0, 2'b00, 32'h4000_0000};
    tv[3] = '{32'hF000_0005, 1'b1, 1'b1, 1'b0, 2'b10, 32'h5000_0000};
    tv[4] = '{32'h0000_000A, 1'b1, 1'b0, 1'b0, 2'b00, 32'hAF00_0000};
    tv[5] = '{32'h0000_0003, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0C00_0000};
    tv[6] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0000_0000};
    clear_bad();
    pay_en = 0;
    step(1'b1, 32'hFFFF_FFFF);
    chk("reset_outputs", {o_data, o_hdr, o_hdr_valid, o_valid, o_block_lock, o_slip}, 0);
    foreach (tv[i]) begin
      step(1'b0, tv[i].din);
      chk("tbl_valid", o_valid, tv[i].v);
      chk("tbl_hdr_valid", o_hdr_valid, tv[i].hv);
      chk("tbl_slip", o_slip, tv[i].slip);
      if (tv[i].v) chk("tbl_data", o_data, tv[i].data);
      if (tv[i].hv) chk("tbl_hdr", o_hdr, tv[i].hdr);
    end
    step(1'b1, $urandom());
    restart(0);
    pay_en = 1;
    run_to_lock(400);
    chk("lock_at_hdr64", hdr_cnt, 64);
    chk("aligned_no_slip", slip_cnt, 0);
    nv = 0;
    nh = 0;
    for (int i = 0; i < 330; i++) begin
      step(1'b0, gen_word());
      nv += int'(o_valid);
      nh += int'(o_hdr_valid);
    end
    chk("thru_valid", nv, 320);
    chk("thru_hdr_valid", nh, 160);
    chk("thru_lock", o_block_lock, 1);
    for (int i = 64; i < 320; i++) bad[i] = (i % 64 >= 10) && (i % 64 < 25);
    step(1'b1, $urandom());
    chk("midlock_reset_outputs", {o_data, o_hdr, o_hdr_valid, o_valid, o_block_lock, o_slip}, 0);
    restart(0);
    run_to_lock(400);
    chk("relock_at_hdr64", hdr_cnt, 64);
    drops = 0;
    cyc = 0;
    while (ob < 330 && cyc < 1200) begin
      step(1'b0, gen_word());
      drops += int'(o_slip || !o_block_lock);
      cyc++;
    end
    chk("retain_blocks", ob >= 330, 1);
    chk("retain_drops", drops, 0);
    chk("retain_slips", slip_cnt, 0);
    clear_bad();
    for (int i = 70; i < 86; i++) bad[i] = 1'b1;
    step(1'b1, $urandom());
    restart(0);
    locked = 0;
    cyc = 0;
    while (cyc < 1000 && !(locked && !o_block_lock)) begin
      step(1'b0, gen_word());
      locked |= o_block_lock;
      cyc++;
    end
    pay_en = 0;
    chk("loss_fell", locked && !o_block_lock, 1);
    chk("loss_at_hdr86", hdr_cnt, 86);
    chk("loss_slip", o_slip, 1);
    chk("loss_slip_cnt", slip_cnt, 1);
    for (int i = 0; i < 200; i++) step(1'b0, gen_word());
    clear_bad();
    step(1'b1, $urandom());
    restart(37);
    run_to_lock(6000);
    chk("mis_slips_in_range", slip_cnt >= 1 && slip_cnt <= 66, 1);
    cyc = 0;
    while (!o_hdr_valid && cyc < 10) begin
      step(1'b0, gen_word());
      cyc++;
    end
    h = o_hdr;
    lo = o_data;
    step(1'b0, gen_word());
    while (!o_valid && cyc < 10) begin
      step(1'b0, gen_word());
      cyc++;
    end
    hi = o_data;
    found = 0;
    k = 0;
    for (int i = 0; i < gi; i++)
      if (!found && src_hdr[i] == h && src_lo[i] == lo && src_hi[i] == hi) begin
        found = 1;
        k = i;
      end
    chk("mis_block_found", found, 1);
    ob = k + 1;
    pay_en = found;
    for (int i = 0; i < 100; i++) step(1'b0, gen_word());
    chk("mis_still_locked", o_block_lock, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
